// File: rtl/chimera_cluster_ctrl_apb.sv
// APB completer for the Chimera cluster control window: clock enables, scratch/ID
// and a per-cluster counted soft-reset sequencer. Optional macro: CHIMERA_CLU_CTRL_PSTRB_EN.
module chimera_cluster_ctrl_apb #(
  parameter int unsigned NumClusters      = 5,
  parameter int unsigned AddrWidth        = 32,
  parameter logic [7:0]  RstCyclesDefault = 8'd16,
  parameter logic [31:0] BlockId          = 32'hC1C0_0001
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AddrWidth-1:0]   paddr_i,
  input  logic                   psel_i,
  input  logic                   penable_i,
  input  logic                   pwrite_i,
  input  logic [31:0]            pwdata_i,
  input  logic [3:0]             pstrb_i,
  output logic                   pready_o,
  output logic [31:0]            prdata_o,
  output logic                   pslverr_o,
  output logic [NumClusters-1:0] cluster_clk_en_o,
  output logic [NumClusters-1:0] cluster_rst_o,
  output logic [NumClusters-1:0] rst_done_o
);

  // Handshake: a transfer is setup (psel & !penable), one fixed wait state, then a
  // single cycle with pready high; writes take effect on the clock edge ending that cycle.
  typedef enum logic [1:0] {Idle, Wait, Resp} apbState_e;

  apbState_e stateQ, stateD;

  logic [11:0]            offset;
  logic                   addrErr, reqErr, wrEn;
  logic [31:0]            byteMask;
  logic [31:0]            rdataNext, rdataQ;
  logic                   errQ;

  logic [NumClusters-1:0] clkEnQ;
  logic [7:0]             rstCyclesQ;
  logic [31:0]            scratchQ;
  logic [NumClusters-1:0] rstReq, busy, clusterRst, clusterDone;
  logic [7:0]             loadVal;
  logic                   unusedBits;

  assign offset  = paddr_i[11:0];
  assign addrErr = (offset >= 12'h018) || (offset[1:0] != 2'b00);
  assign reqErr  = addrErr || (pwrite_i && ((offset == 12'h008) || (offset == 12'h014)));

`ifdef CHIMERA_CLU_CTRL_PSTRB_EN
  assign byteMask   = {{8{pstrb_i[3]}}, {8{pstrb_i[2]}}, {8{pstrb_i[1]}}, {8{pstrb_i[0]}}};
  assign unusedBits = ^paddr_i[AddrWidth-1:12];
`else
  assign byteMask   = '1;
  assign unusedBits = ^{paddr_i[AddrWidth-1:12], pstrb_i};
`endif

  // APB FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stateQ <= Idle;
    else       stateQ <= stateD;
  end

  // APB FSM: next state; a dropped psel abandons the transfer with no side effect
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      Idle:    if (psel_i && !penable_i) stateD = Wait;
      Wait:    stateD = psel_i ? Resp : Idle;
      Resp:    stateD = Idle;
      default: stateD = Idle;
    endcase
  end

  // APB FSM: outputs
  always_comb begin
    pready_o  = (stateQ == Resp);
    prdata_o  = (stateQ == Resp) ? rdataQ : 32'h0;
    pslverr_o = (stateQ == Resp) ? errQ : 1'b0;
  end

  always_comb begin
    rdataNext = '0;
    if (!pwrite_i && !reqErr) begin
      case (offset)
        12'h000: rdataNext[NumClusters-1:0] = clkEnQ;
        12'h004: rdataNext[NumClusters-1:0] = busy;
        12'h008: rdataNext[NumClusters-1:0] = clusterRst;
        12'h00C: rdataNext[7:0]             = rstCyclesQ;
        12'h010: rdataNext                  = scratchQ;
        12'h014: rdataNext                  = BlockId;
        default: rdataNext                  = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdataQ <= '0;
      errQ   <= 1'b0;
    end else if (stateQ == Wait) begin
      rdataQ <= rdataNext;
      errQ   <= reqErr;
    end
  end

  assign wrEn = (stateQ == Resp) && psel_i && pwrite_i && !errQ;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clkEnQ     <= '0;
      rstCyclesQ <= RstCyclesDefault;
      scratchQ   <= '0;
    end else if (wrEn) begin
      case (offset)
        12'h000: clkEnQ     <= (clkEnQ & ~byteMask[NumClusters-1:0])
                             | (pwdata_i[NumClusters-1:0] & byteMask[NumClusters-1:0]);
        12'h00C: rstCyclesQ <= (rstCyclesQ & ~byteMask[7:0]) | (pwdata_i[7:0] & byteMask[7:0]);
        12'h010: scratchQ   <= (scratchQ & ~byteMask) | (pwdata_i & byteMask);
        default: ;
      endcase
    end
  end

  assign rstReq  = (wrEn && (offset == 12'h004))
                 ? (pwdata_i[NumClusters-1:0] & byteMask[NumClusters-1:0]) : '0;
  assign loadVal = (rstCyclesQ == 8'd0) ? 8'd1 : rstCyclesQ;

  // A zero counter means "accepts a request": either READY or the post-reset hold.
  for (genvar g = 0; g < NumClusters; g++) begin : gSeq
    logic [7:0] cntQ;
    logic       rstQ, doneQ;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cntQ  <= '0;
        rstQ  <= 1'b1;
        doneQ <= 1'b0;
      end else begin
        doneQ <= 1'b0;
        if (cntQ != 8'd0) begin
          cntQ <= cntQ - 8'd1;
          if (cntQ == 8'd1) begin
            rstQ  <= 1'b0;
            doneQ <= 1'b1;
          end
        end else if (rstReq[g]) begin
          rstQ <= 1'b1;
          cntQ <= loadVal;
        end
      end
    end

    assign busy[g]        = (cntQ != 8'd0);
    assign clusterRst[g]  = rstQ;
    assign clusterDone[g] = doneQ;
  end

  assign cluster_rst_o    = clusterRst;
  assign rst_done_o       = clusterDone;
  assign cluster_clk_en_o = clkEnQ | busy;

endmodule

// File: tb/tb_chimera_cluster_ctrl_apb.sv
// Directed bench for chimera_cluster_ctrl_apb: register map, transfer latency,
// reset sequencer timing, error responses and byte strobes.
module tb_chimera_cluster_ctrl_apb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] paddr_i;
  logic        psel_i, penable_i, pwrite_i;
  logic [31:0] pwdata_i;
  logic [3:0]  pstrb_i;
  logic        pready_o, pslverr_o;
  logic [31:0] prdata_o;
  logic [4:0]  cluster_clk_en_o, cluster_rst_o, rst_done_o;

  int checks   = 0;
  int failures = 0;

  chimera_cluster_ctrl_apb dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .paddr_i          (paddr_i),
    .psel_i           (psel_i),
    .penable_i        (penable_i),
    .pwrite_i         (pwrite_i),
    .pwdata_i         (pwdata_i),
    .pstrb_i          (pstrb_i),
    .pready_o         (pready_o),
    .prdata_o         (prdata_o),
    .pslverr_o        (pslverr_o),
    .cluster_clk_en_o (cluster_clk_en_o),
    .cluster_rst_o    (cluster_rst_o),
    .rst_done_o       (rst_done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one transfer; lat is the number of access-phase cycles before pready (-1 on timeout).
  task automatic apbXfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                         input logic [3:0] strb, output logic [31:0] rdata,
                         output logic err, output int lat);
    @(negedge clk_i);
    paddr_i = addr; pwrite_i = wr; pwdata_i = wdata; pstrb_i = strb;
    psel_i = 1'b1; penable_i = 1'b0;
    @(negedge clk_i);
    penable_i = 1'b1;
    lat = -1; rdata = '0; err = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (pready_o) begin
        rdata = prdata_o; err = pslverr_o; lat = i;
        break;
      end
      @(negedge clk_i);
    end
    @(posedge clk_i);
    #1;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
  endtask

  task automatic apbWrite(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic expErr);
    logic [31:0] rd; logic er; int lat;
    apbXfer(addr, 1'b1, data, strb, rd, er, lat);
    check({tag, "_lat"}, lat, 1);
    check({tag, "_err"}, {31'b0, er}, {31'b0, expErr});
    check({tag, "_rdata"}, rd, 32'h0);
  endtask

  task automatic apbRead(input string tag, input logic [31:0] addr,
                         input logic [31:0] expData, input logic expErr);
    logic [31:0] rd; logic er; int lat;
    apbXfer(addr, 1'b0, 32'h0, 4'h0, rd, er, lat);
    check({tag, "_lat"}, lat, 1);
    check({tag, "_err"}, {31'b0, er}, {31'b0, expErr});
    check({tag, "_data"}, rd, expData);
  endtask

  int          highCnt, doneCnt;
  logic [31:0] scratchExp;

  initial begin
    rst_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = '0; pwdata_i = '0; pstrb_i = 4'hF;
    repeat (3) @(negedge clk_i);
    check("rst_pready",  {31'b0, pready_o},  32'h0);
    check("rst_prdata",  prdata_o,           32'h0);
    check("rst_pslverr", {31'b0, pslverr_o}, 32'h0);
    check("rst_clk_en",  {27'b0, cluster_clk_en_o}, 32'h0);
    check("rst_cl_rst",  {27'b0, cluster_rst_o},    32'h1F);
    check("rst_done",    {27'b0, rst_done_o},       32'h0);
    rst_i = 1'b0;

    apbRead("id", 32'h3000_1014, 32'hC1C0_0001, 1'b0);
    apbRead("status0", 32'h3000_1008, 32'h1F, 1'b0);
    apbRead("clken0", 32'h3000_1000, 32'h0, 1'b0);
    apbRead("cycles0", 32'h3000_100C, 32'h10, 1'b0);

    apbWrite("wr_clken", 32'h3000_1000, 32'h5, 4'hF, 1'b0);
    @(negedge clk_i);
    check("clk_en_out", {27'b0, cluster_clk_en_o}, 32'h05);
    apbRead("clken_rb", 32'h3000_1000, 32'h5, 1'b0);

    // 3-cycle sequence on cluster 1
    apbWrite("wr_cyc3", 32'h3000_100C, 32'd3, 4'hF, 1'b0);
    apbWrite("req_c1", 32'h3000_1004, 32'h2, 4'hF, 1'b0);
    highCnt = 0; doneCnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check($sformatf("seq3_rst_k%0d", k), {31'b0, cluster_rst_o[1]}, (k < 3) ? 32'h1 : 32'h0);
      check($sformatf("seq3_done_k%0d", k), {31'b0, rst_done_o[1]}, (k == 3) ? 32'h1 : 32'h0);
      check($sformatf("seq3_clk_k%0d", k), {27'b0, cluster_clk_en_o}, (k < 3) ? 32'h7 : 32'h5);
    end
    apbRead("status_1d", 32'h3000_1008, 32'h1D, 1'b0);
    apbRead("busy_idle", 32'h3000_1004, 32'h0, 1'b0);

    // RST_CYCLES=0 gives a single reset cycle
    apbWrite("wr_cyc0", 32'h3000_100C, 32'd0, 4'hF, 1'b0);
    apbWrite("req_c0a", 32'h3000_1004, 32'h1, 4'hF, 1'b0);
    highCnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      if (cluster_rst_o[0]) highCnt++;
    end
    check("seq0_len", highCnt, 1);

    // 8-cycle hold: the second request lands 3 cycles in and must not restart it,
    // so 5 cycles of reset remain after it commits
    apbWrite("wr_cyc8", 32'h3000_100C, 32'd8, 4'hF, 1'b0);
    apbWrite("req_c0b", 32'h3000_1004, 32'h1, 4'hF, 1'b0);
    apbWrite("req_c0c", 32'h3000_1004, 32'h1, 4'hF, 1'b0);
    highCnt = 0; doneCnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      if (cluster_rst_o[0]) highCnt++;
      if (rst_done_o[0]) doneCnt++;
    end
    check("seq8_remaining", highCnt, 5);
    check("seq8_done", doneCnt, 1);

    apbWrite("req_c4", 32'h3000_1004, 32'h10, 4'hF, 1'b0);
    apbRead("busy_c4", 32'h3000_1004, 32'h10, 1'b0);
    repeat (10) @(negedge clk_i);
    apbRead("status_0c", 32'h3000_1008, 32'h0C, 1'b0);

    // Error responses leave state untouched
    apbRead("err_rd40", 32'h3000_1040, 32'h0, 1'b1);
    apbWrite("err_wr_id", 32'h3000_1014, 32'h0, 4'hF, 1'b1);
    apbRead("id_after", 32'h3000_1014, 32'hC1C0_0001, 1'b0);
    apbRead("err_rd06", 32'h3000_1006, 32'h0, 1'b1);
    apbWrite("err_wr_stat", 32'h3000_1008, 32'h0, 4'hF, 1'b1);
    apbWrite("err_wr40", 32'h3000_1040, 32'hFFFF_FFFF, 4'hF, 1'b1);
    apbRead("clken_after", 32'h3000_1000, 32'h5, 1'b0);
    apbRead("status_after", 32'h3000_1008, 32'h0C, 1'b0);

    // Byte strobes
    apbWrite("scr_ff", 32'h3000_1010, 32'hFFFF_FFFF, 4'hF, 1'b0);
    apbWrite("scr_strb", 32'h3000_1010, 32'h1234_5678, 4'b0010, 1'b0);
`ifdef CHIMERA_CLU_CTRL_PSTRB_EN
    scratchExp = 32'hFFFF_56FF;
`else
    scratchExp = 32'h1234_5678;
`endif
    apbRead("scr_rb", 32'h3000_1010, scratchExp, 1'b0);

    // psel dropped during the wait state: nothing is written
    @(negedge clk_i);
    paddr_i = 32'h3000_1010; pwrite_i = 1'b1; pwdata_i = 32'hDEAD_BEEF; pstrb_i = 4'hF;
    psel_i = 1'b1; penable_i = 1'b0;
    @(negedge clk_i);
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    repeat (2) @(negedge clk_i);
    apbRead("scr_drop", 32'h3000_1010, scratchExp, 1'b0);

    // Asynchronous reset in the middle of a sequence
    apbWrite("req_c0d", 32'h3000_1004, 32'h1, 4'hF, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("mid_rst_cl_rst", {27'b0, cluster_rst_o}, 32'h1F);
    check("mid_rst_clk_en", {27'b0, cluster_clk_en_o}, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    apbRead("busy_after_rst", 32'h3000_1004, 32'h0, 1'b0);
    apbRead("cycles_after_rst", 32'h3000_100C, 32'h10, 1'b0);
    apbRead("scr_after_rst", 32'h3000_1010, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog time_limit observed=expired required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
